edge_to_level: RTL and testbench
================================

EDGE_TO_LEVEL -- requirements
Module: edge_to_level

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, legal range 2..16: width of the pulse-width counter and of width_out.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port lead_pulse, input, 1 bit: one-cycle leading-edge event from an edge detector.
REQ-005 The block SHALL have port trail_pulse, input, 1 bit: one-cycle trailing-edge event from an edge detector.
REQ-006 The block SHALL have port level_out, output, 1 bit: the reconstructed level.
REQ-007 The block SHALL have port width_out, output, CNT_W bits: the high-period length in clk cycles, valid only with width_valid.
REQ-008 The block SHALL have port width_valid, output, 1 bit: a one-cycle strobe marking a completed high period.
REQ-009 The block SHALL have port width_sat, output, 1 bit: qualifies width_valid; the measured width saturated.
REQ-010 The block SHALL have port err_dup_lead, output, 1 bit: one-cycle pulse; lead_pulse arrived while already HIGH.
REQ-011 The block SHALL have port err_dup_trail, output, 1 bit: one-cycle pulse; trail_pulse arrived while already LOW.
REQ-012 The block SHALL have port err_both, output, 1 bit: one-cycle pulse; lead_pulse and trail_pulse arrived in the same cycle.

Function
REQ-013 The block SHALL implement a two-state FSM, LOW and HIGH, with level_out driven directly from a register and equal to 1 only in HIGH.
REQ-014 In LOW, lead_pulse=1 with trail_pulse=0 SHALL move the FSM to HIGH, load the counter with 1, and raise level_out one cycle after lead_pulse is sampled.
REQ-015 In HIGH, a cycle with no events SHALL increment the counter, saturating at 2^CNT_W-1, which then holds.
REQ-016 In HIGH, trail_pulse=1 with lead_pulse=0 SHALL move the FSM to LOW, register width_out=counter, assert width_valid for exactly one cycle, and lower level_out one cycle after trail_pulse is sampled.
REQ-017 Width semantics: a lead sampled at cycle t and a trail sampled at cycle t+N SHALL give width_out=N, equal to the number of cycles level_out was 1; back-to-back (N=1) SHALL give 1.
REQ-018 width_sat SHALL be 1 with width_valid when the reported width equals 2^CNT_W-1; otherwise it SHALL be 0.
REQ-019 In HIGH, lead_pulse alone SHALL pulse err_dup_lead for one cycle; the state and counter SHALL continue as a no-event cycle.
REQ-020 In LOW, trail_pulse alone SHALL pulse err_dup_trail for one cycle, with the state unchanged and no width_valid.
REQ-021 lead_pulse and trail_pulse both 1 in any state SHALL pulse err_both, leave the state unchanged, and count as a no-event cycle in HIGH; no other error flag SHALL assert in that cycle.
REQ-022 width_out SHALL hold its last reported value between strobes.
REQ-023 All error and strobe outputs SHALL be registered, with exactly one cycle of latency from the sampled event.
REQ-024 A lead_pulse sampled in the same cycle that HIGH->LOW completes (the cycle after trail) SHALL be handled as a normal LOW-state lead, re-entering HIGH immediately.

Reset
REQ-025 Asserting rst SHALL immediately force the FSM to LOW and clear the counter, level_out, width_out, width_valid, width_sat and all err_* outputs to 0.
REQ-026 rst asserted mid-HIGH SHALL abandon the period and SHALL NOT produce a width_valid for it, during or after reset.
REQ-027 The first event SHALL be evaluated on the first rising clk edge after rst deasserts.

Structure
REQ-028 The FSM state enum (LOW, HIGH) SHALL reside in the shared package edge_to_level_pkg.
REQ-029 The saturating counter SHALL be the sub-module sat_counter, with ports for load-1, increment, and a saturated flag, parameterised by CNT_W.
REQ-030 No other sub-modules SHALL be used.

Verification
REQ-031 Scenario: lead at cycle 10, trail at cycle 15 -> level_out=1 in cycles 11..15; width_valid at 16 with width_out=5 and width_sat=0.
REQ-032 Scenario: lead and trail on consecutive cycles -> level_out high for 1 cycle; width_out=1.
REQ-033 Scenario: CNT_W=4, lead, then 40 idle cycles, then trail -> width_out=15 and width_sat=1 with width_valid.
REQ-034 Scenario: lead, lead 3 cycles later, trail 3 cycles after that -> a single err_dup_lead pulse, then width_out=6; also, a trail while LOW -> err_dup_trail with no width_valid.
REQ-035 Scenario: lead and trail asserted together in LOW and in HIGH -> err_both each time, state unchanged, and the HIGH-state counter keeps incrementing.
REQ-036 Scenario: rst asserted asynchronously mid-HIGH (between edges) -> level_out=0 immediately, no width_valid afterward, and the next lead/trail pair measured correctly.

Source files
------------

// File: rtl/edge_to_level_pkg.sv
// Shared types for the edge_to_level block: the level-reconstruction FSM states.
package edge_to_level_pkg;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to measure the high period: load-to-1, increment, sticky at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign sat = (count == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_ONE;
    end else if (inc && !sat) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/edge_to_level.sv
// Rebuilds a level from leading/trailing edge pulses, measures each high period
// and flags protocol violations (duplicate or simultaneous edges).
module edge_to_level
  import edge_to_level_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lead_pulse,
  input  logic             trail_pulse,
  output logic             level_out,
  output logic [CNT_W-1:0] width_out,
  output logic             width_valid,
  output logic             width_sat,
  output logic             err_dup_lead,
  output logic             err_dup_trail,
  output logic             err_both
);

  state_t           state;
  state_t           state_next;
  logic             load_one;
  logic             inc;
  logic [CNT_W-1:0] count;
  logic             cnt_sat;
  logic             valid_next;
  logic             dup_lead_next;
  logic             dup_trail_next;
  logic             both_next;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_one (load_one),
    .inc      (inc),
    .count    (count),
    .sat      (cnt_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOW;
    end else begin
      state <= state_next;
    end
  end

  // Simultaneous edges are ambiguous: report them and treat the cycle as idle.
  always_comb begin
    state_next     = state;
    load_one       = 1'b0;
    inc            = 1'b0;
    valid_next     = 1'b0;
    dup_lead_next  = 1'b0;
    dup_trail_next = 1'b0;
    both_next      = 1'b0;
    if (lead_pulse && trail_pulse) begin
      both_next = 1'b1;
      inc       = (state == ST_HIGH);
    end else begin
      case (state)
        ST_LOW: begin
          if (lead_pulse) begin
            state_next = ST_HIGH;
            load_one   = 1'b1;
          end else if (trail_pulse) begin
            dup_trail_next = 1'b1;
          end else begin
            state_next = ST_LOW;
          end
        end
        ST_HIGH: begin
          if (trail_pulse) begin
            state_next = ST_LOW;
            valid_next = 1'b1;
          end else begin
            inc           = 1'b1;
            dup_lead_next = lead_pulse;
          end
        end
        default: begin
          state_next = ST_LOW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_out     <= 1'b0;
      width_out     <= '0;
      width_valid   <= 1'b0;
      width_sat     <= 1'b0;
      err_dup_lead  <= 1'b0;
      err_dup_trail <= 1'b0;
      err_both      <= 1'b0;
    end else begin
      level_out     <= (state_next == ST_HIGH);
      width_valid   <= valid_next;
      width_sat     <= valid_next & cnt_sat;
      err_dup_lead  <= dup_lead_next;
      err_dup_trail <= dup_trail_next;
      err_both      <= both_next;
      if (valid_next) begin
        width_out <= count;
      end else begin
        width_out <= width_out;
      end
    end
  end

endmodule

// File: tb/tb_edge_to_level.sv
// Scoreboard bench for edge_to_level (CNT_W=4): directed edge sequences push
// expected strobes/errors; a negedge monitor pops and compares them.
module tb_edge_to_level;

  localparam int W = 4;
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_V    = 5'b10000;
  localparam logic [4:0] F_VS   = 5'b11000;
  localparam logic [4:0] F_DL   = 5'b00100;
  localparam logic [4:0] F_DT   = 5'b00010;
  localparam logic [4:0] F_B    = 5'b00001;

  typedef struct {
    int          cyc;
    logic [4:0]  fl;
    logic [W-1:0] w;
    string       nm;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         lead_pulse;
  logic         trail_pulse;
  logic         level_out;
  logic [W-1:0] width_out;
  logic         width_valid;
  logic         width_sat;
  logic         err_dup_lead;
  logic         err_dup_trail;
  logic         err_both;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  string scen     = "reset";
  exp_t  sb[$];

  edge_to_level #(.CNT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .lead_pulse    (lead_pulse),
    .trail_pulse   (trail_pulse),
    .level_out     (level_out),
    .width_out     (width_out),
    .width_valid   (width_valid),
    .width_sat     (width_sat),
    .err_dup_lead  (err_dup_lead),
    .err_dup_trail (err_dup_trail),
    .err_both      (err_both)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s/%s: got %0d expected %0d", scen, nm, act, exp_v);
    end
  endtask

  // Drive one cycle of edge pulses; lvl is the level expected before this edge.
  task automatic ev(input logic l, input logic t, input logic lvl,
                    input logic [4:0] fl, input logic [W-1:0] w);
    exp_t e;
    @(negedge clk);
    chk("level", int'(level_out), int'(lvl));
    lead_pulse  = l;
    trail_pulse = t;
    if (fl != F_NONE) begin
      e.cyc = cyc + 1;
      e.fl  = fl;
      e.w   = w;
      e.nm  = scen;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
  endtask

  task automatic chk_cleared();
    chk("level_rst", int'(level_out), 0);
    chk("width_rst", int'(width_out), 0);
    chk("strobes_rst", int'({width_valid, width_sat, err_dup_lead, err_dup_trail, err_both}), 0);
  endtask

  // Monitor: every non-zero strobe/error vector must match the queue head for this cycle.
  always @(negedge clk) begin
    logic [4:0] act;
    exp_t       e;
    act = {width_valid, width_sat, err_dup_lead, err_dup_trail, err_both};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s/missing: flags %b expected at cycle %0d were not observed", e.nm, e.fl, e.cyc);
    end
    if (act != F_NONE) begin
      checks++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        failures++;
        $display("FAIL %s/unexpected: flags %b width %0d at cycle %0d, expected none", scen, act, width_out, cyc);
      end else begin
        e = sb.pop_front();
        if (act !== e.fl || (e.fl[4] && width_out !== e.w)) begin
          failures++;
          $display("FAIL %s/strobe: flags %b width %0d, expected flags %b width %0d",
                   e.nm, act, width_out, e.fl, e.w);
        end
      end
    end
  end

  initial begin
    rst         = 1'b0;
    lead_pulse  = 1'b0;
    trail_pulse = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cleared();
    rst = 1'b0;

    scen = "basic_w5";
    idle_low: begin
      ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    end
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    idle(4);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd5);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    chk("width_hold", int'(width_out), 5);

    scen = "back_to_back";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd1);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "w14_nosat";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    idle(13);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd14);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "saturate";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    idle(40);
    ev(1'b0, 1'b1, 1'b1, F_VS, 4'd15);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "dup_lead";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    idle(2);
    ev(1'b1, 1'b0, 1'b1, F_DL, 4'd0);
    idle(2);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd6);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "dup_trail";
    ev(1'b0, 1'b1, 1'b0, F_DT, 4'd0);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    chk("width_hold2", int'(width_out), 6);

    scen = "both";
    ev(1'b1, 1'b1, 1'b0, F_B, 4'd0);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
    ev(1'b1, 1'b1, 1'b1, F_B, 4'd0);
    ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd4);

    scen = "relead";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd1);
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd2);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "async_rst";
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b1, F_NONE, 4'd0);
    #2 rst = 1'b1;
    #1 chk_cleared();
    repeat (2) @(negedge clk);
    chk_cleared();
    rst = 1'b0;
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);
    ev(1'b1, 1'b0, 1'b0, F_NONE, 4'd0);
    idle(2);
    ev(1'b0, 1'b1, 1'b1, F_V, 4'd3);
    ev(1'b0, 1'b0, 1'b0, F_NONE, 4'd0);

    scen = "drain";
    repeat (3) @(negedge clk);
    chk("queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
